// File: rtl/i2s_codec_master.sv
// i2s_codec_master
//   Codec-side (WM8731-style) master for the audio serial link. Generates
//   BCLK and LRCK and serializes ADC words onto aud_adcdat. It also
//   deserializes aud_dacdat into parallel words.
//
// Build option:
//   CODEC_LJ_FORMAT_EN
//     Defined:   left-justified framing. There is no delay bit, lrck=1 marks
//                the left slot, and lrck idles high.
//     Undefined: I2S framing with a one-bit delay. lrck=0 marks the left slot
//                and lrck idles low.
//
// Handshake:
//   A tx word is accepted in any cycle where tx_valid and tx_ready are both 1.
//   tx_ready is 1 exactly while the one-word holding buffer is empty.
//   rx_valid is a one-cycle strobe with no backpressure.
//
// Debug:
//   dbg_state exposes the FSM state (0 IDLE, 1 RUN, 2 DRAIN).
module i2s_codec_master #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int HALF_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              aud_bclk,
  output logic              aud_lrck,
  output logic              aud_adcdat,
  input  logic              aud_dacdat,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_channel,
  output logic              underrun,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int K_W   = $clog2(SLOT_W);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(HALF_DIV - 1);
  localparam logic [K_W-1:0]   K_LAST = K_W'(SLOT_W - 1);

`ifdef CODEC_LJ_FORMAT_EN
  localparam logic           LRCK_IDLE = 1'b1;
  localparam logic [K_W-1:0] TX_LAST   = K_W'(DATA_W - 1);
  localparam logic [K_W-1:0] RX_LAST   = K_W'(DATA_W - 1);
`else
  localparam logic           LRCK_IDLE = 1'b0;
  localparam logic [K_W-1:0] TX_LAST   = K_W'(DATA_W);
  localparam logic [K_W-1:0] RX_LAST   = K_W'(DATA_W);
`endif
  // The left slot is the idle level, so the right slot is the other level.
  localparam logic LRCK_RIGHT = ~LRCK_IDLE;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic                r_bclk;
  logic                r_lrck;
  logic [K_W-1:0]      r_k;
  logic [DATA_W-1:0]   r_tx_sh;
  logic                r_adcdat;
  logic [DATA_W-1:0]   r_buf;
  logic                r_buf_full;
  logic                r_underrun;
  logic [DATA_W-1:0]   r_rx_sh;
  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rx_valid;
  logic                r_rx_ch;

  logic                w_tick;
  logic                w_fall;
  logic                w_rise;
  logic [K_W-1:0]      w_k_next;
  logic                w_wrap;
  logic                w_write;
  logic                w_to_idle;
  logic                w_rx_bit;
  logic [DATA_W-1:0]   w_load_word;
  logic [DATA_W-1:0]   w_load_sh;
  logic                w_load_adc;

  // Edge strobes: a strobe marks the clk cycle in which the registered bclk changes.
  assign w_tick    = (r_state != IDLE) && (r_div == DIV_TC);
  assign w_fall    = w_tick && r_bclk;
  assign w_rise    = w_tick && !r_bclk;
  assign w_k_next  = (r_k == K_LAST) ? '0 : r_k + K_W'(1);
  assign w_wrap    = w_fall && (r_k == K_LAST);
  assign w_write   = tx_valid && !r_buf_full;
  assign w_to_idle = (r_state == DRAIN) && !enable && w_wrap && (r_lrck == LRCK_RIGHT);
  // An empty buffer at slot start sends an all-zero word.
  assign w_load_word = r_buf_full ? r_buf : '0;

`ifdef CODEC_LJ_FORMAT_EN
  // Left-justified: the MSB goes out on the slot-start edge itself.
  assign w_load_adc = w_load_word[DATA_W-1];
  assign w_load_sh  = {w_load_word[DATA_W-2:0], 1'b0};
  assign w_rx_bit   = (r_k <= RX_LAST);
`else
  // I2S: the slot-start bit is the delay bit and is always 0.
  assign w_load_adc = 1'b0;
  assign w_load_sh  = w_load_word;
  assign w_rx_bit   = (r_k != '0) && (r_k <= RX_LAST);
`endif

  // FSM together with the clock generation, framing, tx holding buffer and tx shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_bclk     <= 1'b0;
      r_lrck     <= LRCK_IDLE;
      r_k        <= '0;
      r_tx_sh    <= '0;
      r_adcdat   <= 1'b0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_write) begin
        r_buf      <= tx_data;
        r_buf_full <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (enable) begin
            // RUN entry counts as a slot start. A same-cycle write stays in the buffer.
            r_state    <= RUN;
            r_tx_sh    <= w_load_sh;
            r_adcdat   <= w_load_adc;
            r_buf_full <= w_write;
            r_underrun <= ~r_buf_full;
          end
        end
        RUN, DRAIN: begin
          r_div <= (r_div == DIV_TC) ? '0 : r_div + DIV_W'(1);
          if (w_tick) r_bclk <= ~r_bclk;
          if (w_fall) begin
            r_k <= w_k_next;
            if (w_wrap) begin
              r_lrck     <= ~r_lrck;
              r_tx_sh    <= w_load_sh;
              r_adcdat   <= w_load_adc;
              r_buf_full <= w_write;
              r_underrun <= ~r_buf_full;
            end else if (w_k_next <= TX_LAST) begin
              r_adcdat <= r_tx_sh[DATA_W-1];
              r_tx_sh  <= {r_tx_sh[DATA_W-2:0], 1'b0};
            end else begin
              r_adcdat <= 1'b0;
            end
          end
          if (w_to_idle) begin
            // The last falling edge of the right slot parks everything.
            // The holding buffer keeps its word and is not loaded here.
            r_state    <= IDLE;
            r_div      <= '0;
            r_bclk     <= 1'b0;
            r_lrck     <= LRCK_IDLE;
            r_k        <= '0;
            r_tx_sh    <= '0;
            r_adcdat   <= 1'b0;
            r_buf_full <= r_buf_full | w_write;
            r_underrun <= 1'b0;
          end else if (r_state == RUN && !enable) begin
            r_state <= DRAIN;
          end else if (r_state == DRAIN && enable) begin
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Receive path: sample dacdat on rising edges of the data bits and publish each complete word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ch    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_to_idle) begin
        r_rx_sh <= '0;
      end else if (w_rise && w_rx_bit) begin
        r_rx_sh <= {r_rx_sh[DATA_W-2:0], aud_dacdat};
        if (r_k == RX_LAST) begin
          r_rx_data  <= {r_rx_sh[DATA_W-2:0], aud_dacdat};
          r_rx_valid <= 1'b1;
          r_rx_ch    <= r_lrck;
        end
      end
    end
  end

  assign aud_bclk   = r_bclk;
  assign aud_lrck   = r_lrck;
  assign aud_adcdat = r_adcdat;
  assign tx_ready   = ~r_buf_full;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_channel = r_rx_ch;
  assign underrun   = r_underrun;
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;

endmodule
